// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the word-indexed fetch PC, drives the instruction memory address and
// buffers returned instructions, tagged with their PC, in a small circular
// prefetch queue. The queue feeds the decoder over a valid/ready handshake.
// A branch redirect flushes the queue and restarts fetch at the target.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_stalls.
module fetch_unit #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_adr,
    input  logic [31:0] imem_ins,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
`endif
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C    = DEPTH[AW:0];
    localparam logic [31:0] PC_MASK    = IMEM_WORDS - 1;
    localparam logic [31:0] RESET_PC_C = RESET_PC;

    logic [31:0] fpc;
    logic [31:0] q_pc  [DEPTH];
    logic [31:0] q_ins [DEPTH];
    logic [AW:0] rptr;
    logic [AW:0] wptr;
    logic [AW:0] count;
    logic [31:0] hold_pc;
    logic [31:0] hold_ins;
    logic        deq;
    logic        push;

    // Memory address is purely the fetch PC register.
    assign imem_adr  = fpc;
    assign out_valid = (count != '0);

    // Handshake decode: a push needs a free slot or a slot freed by this deq.
    always_comb begin
        deq  = out_valid & out_ready;
        push = ~redirect & ((count < DEPTH_C) | deq);
    end

    // Head outputs: live queue entry when non-empty, else the last shown values.
    // The hold registers keep out_pc/out_ins frozen while the queue is empty,
    // since the slot under rptr is stale after a drain or flush.
    always_comb begin
        out_pc  = hold_pc;
        out_ins = hold_ins;
        if (out_valid) begin
            out_pc  = q_pc[rptr[AW-1:0]];
            out_ins = q_ins[rptr[AW-1:0]];
        end
    end

    // Fetch PC, queue storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc      <= RESET_PC_C;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            hold_pc  <= '0;
            hold_ins <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_pc[i]  <= '0;
                q_ins[i] <= '0;
            end
        end else begin
            hold_pc  <= out_pc;
            hold_ins <= out_ins;
            if (redirect) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
                fpc   <= redirect_pc & PC_MASK;
            end else begin
                if (push) begin
                    q_pc[wptr[AW-1:0]]  <= fpc;
                    q_ins[wptr[AW-1:0]] <= imem_ins;
                    wptr                <= wptr + 1'b1;
                    fpc                 <= (fpc + 32'd1) & PC_MASK;
                end
                if (deq) begin
                    rptr <= rptr + 1'b1;
                end
                case ({push, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: pushes, and cycles spent full with no dequeue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((count == DEPTH_C) && !deq) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
// (DEPTH=2, RESET_PC=0, IMEM_WORDS=32) with a combinational program image.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_adr;
    logic [31:0] imem_ins;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
`endif

    logic [31:0] mem [32];
    int n_checks;
    int n_fail;

    fetch_unit #(
        .DEPTH      (2),
        .RESET_PC   (0),
        .IMEM_WORDS (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_adr    (imem_adr),
        .imem_ins    (imem_ins),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ins     (out_ins),
        .out_pc      (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stalls (perf_stalls)
`endif
    );

    // Program image: combinational read, same cycle.
    assign imem_ins = mem[imem_adr[4:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'hC000_0000 | i;
        mem[0] = 32'h0011_0202;
        mem[1] = 32'h0011_0203;
        mem[8] = 32'h0011_0203;

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_adr",   imem_adr, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ins",   out_ins, 32'd0);
        chk("rst_pc",    out_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_f", perf_fetched, 32'd0);
        chk("rst_perf_s", perf_stalls, 32'd0);
`endif

        // Reset release, streaming with out_ready=1
        reset = 1'b0;
        step();
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_pc",    out_pc, 32'd0);
        chk("first_ins",   out_ins, 32'h0011_0202);
        step();
        chk("second_pc",  out_pc, 32'd1);
        chk("second_ins", out_ins, 32'h0011_0203);
        step();
        chk("third_pc",  out_pc, 32'd2);
        chk("third_ins", out_ins, 32'hC000_0002);

        // Back-pressure: queue fills, fetch PC freezes
        reset = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b0;
        repeat (5) step();
        chk("full_adr",   imem_adr, 32'd2);
        chk("full_pc",    out_pc, 32'd0);
        chk("full_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("drain_pc1", out_pc, 32'd1);
        step();
        chk("drain_pc2", out_pc, 32'd2);
        chk("drain_ins2", out_ins, 32'hC000_0002);
        step();
        chk("drain_pc3", out_pc, 32'd3);

        // Redirect to 8 while queue holds PCs 3,4
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("pre_redir_pc", out_pc, 32'd3);
        out_ready = 1'b0;
        step();
        chk("pre_redir_adr", imem_adr, 32'd5);
        chk("pre_redir_head", out_pc, 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'd8;
        out_ready   = 1'b1;
        step();
        redirect = 1'b0;
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_adr",   imem_adr, 32'd8);
        chk("bubble_hold_pc", out_pc, 32'd3);
        step();
        chk("redir_valid", {31'd0, out_valid}, 32'd1);
        chk("redir_pc",    out_pc, 32'd8);
        chk("redir_ins",   out_ins, 32'h0011_0203);
        step();
        chk("redir_next_pc", out_pc, 32'd9);
        chk("redir_next_ins", out_ins, 32'hC000_0009);

        // Redirect to 31, PC wrap-around
        redirect    = 1'b1;
        redirect_pc = 32'd31;
        step();
        redirect = 1'b0;
        chk("wrap_bubble", {31'd0, out_valid}, 32'd0);
        chk("wrap_adr31",  imem_adr, 32'd31);
        step();
        chk("wrap_pc31",  out_pc, 32'd31);
        chk("wrap_ins31", out_ins, 32'hC000_001F);
        chk("wrap_adr0",  imem_adr, 32'd0);
        step();
        chk("wrap_pc0",  out_pc, 32'd0);
        chk("wrap_ins0", out_ins, 32'h0011_0202);
        step();
        chk("wrap_pc1", out_pc, 32'd1);

        // Redirect target upper bits are discarded
        redirect    = 1'b1;
        redirect_pc = 32'hABCD_0045;
        step();
        redirect = 1'b0;
        chk("mask_adr", imem_adr, 32'd5);
        step();
        chk("mask_pc", out_pc, 32'd5);

        // Asynchronous reset between edges
        #3;
        reset = 1'b1;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_adr",   imem_adr, 32'd0);
        chk("async_pc",    out_pc, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("restart_pc0", out_pc, 32'd0);
        chk("restart_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("restart_pc1", out_pc, 32'd1);

`ifdef FETCH_PERF_CNT_EN
        // Performance counters: 4 pushes then 3 full stalled cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("perf_clear", perf_fetched, 32'd0);
        repeat (3) step();
        out_ready = 1'b0;
        repeat (4) step();
        chk("perf_fetched", perf_fetched, 32'd4);
        chk("perf_stalls",  perf_stalls, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
